// File: rtl/fir_sample_loader.sv
// Streams signed 8-bit samples into the FIR sample memory, appends PAD zero
// samples per frame, then pulses the filter start and waits for completion.
module fir_sample_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned PAD       = 4,
  parameter int unsigned START_LEN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic              mem_we_b,
  output logic [7:0]        mem_data_in_b,
  output logic              filt_start,
  input  logic              filt_done,
  output logic              busy,
  output logic [ADDR_W:0]   sample_count,
  output logic              overflow
);

  localparam int unsigned CntW = ADDR_W + 1;
  // Samples beyond this count would push the pad past the end of memory.
  localparam logic [CntW-1:0] Limit     = CntW'(DEPTH - PAD);
  localparam logic [CntW-1:0] PadLast   = CntW'((PAD == 0) ? 0 : PAD - 1);
  localparam logic [3:0]      StartLast = 4'(START_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPad,
    StStart,
    StWait
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [CntW-1:0] pad_cnt_q, pad_cnt_d;
  logic [3:0]      start_cnt_q, start_cnt_d;
  logic            we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]      data_q, data_d;

  // Frame-local bookkeeping as seen by the current beat; a beat taken in
  // IDLE starts a fresh frame, so it sees cleared pointer/count/overflow.
  logic [CntW-1:0] ptr_base;
  logic [CntW-1:0] cnt_base;
  logic            ovf_base;
  logic            accept;

  assign s_ready       = (state_q == StIdle) || (state_q == StLoad);
  assign accept        = s_valid && s_ready;
  assign busy          = (state_q != StIdle);
  assign filt_start    = (state_q == StStart);
  assign mem_we_b      = we_q;
  assign mem_addr_b    = addr_q;
  assign mem_data_in_b = data_q;
  assign sample_count  = count_q;
  assign overflow      = ovf_q;

  // Next-state and registered memory-write computation.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    pad_cnt_d   = pad_cnt_q;
    start_cnt_d = start_cnt_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    ptr_base    = wr_ptr_q;
    cnt_base    = count_q;
    ovf_base    = ovf_q;

    unique case (state_q)
      StIdle, StLoad: begin
        if (accept) begin
          if (state_q == StIdle) begin
            ptr_base = '0;
            cnt_base = '0;
            ovf_base = 1'b0;
          end
          if (cnt_base < Limit) begin
            we_d     = 1'b1;
            addr_d   = ptr_base[ADDR_W-1:0];
            data_d   = s_data;
            wr_ptr_d = ptr_base + 1'b1;
            count_d  = cnt_base + 1'b1;
            ovf_d    = ovf_base;
          end else begin
            // Memory full: drop the beat but keep draining to s_last.
            wr_ptr_d = ptr_base;
            count_d  = cnt_base;
            ovf_d    = 1'b1;
          end
          if (s_last) begin
            pad_cnt_d   = '0;
            start_cnt_d = '0;
            state_d     = (PAD == 0) ? StStart : StPad;
          end else begin
            state_d = StLoad;
          end
        end
      end

      StPad: begin
        we_d      = 1'b1;
        addr_d    = wr_ptr_q[ADDR_W-1:0];
        data_d    = 8'h00;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        pad_cnt_d = pad_cnt_q + 1'b1;
        if (pad_cnt_q == PadLast) begin
          start_cnt_d = '0;
          state_d     = StStart;
        end
      end

      StStart: begin
        start_cnt_d = start_cnt_q + 1'b1;
        if (start_cnt_q == StartLast) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (filt_done) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame and pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      pad_cnt_q   <= '0;
      start_cnt_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      pad_cnt_q   <= pad_cnt_d;
      start_cnt_q <= start_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

endmodule

// File: tb/tb_fir_sample_loader.sv
// Directed bench for fir_sample_loader: a frame-level model predicts every
// write, s_ready/busy/filt_start and the counters each cycle.
module tb_fir_sample_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int PAD    = 4;
  localparam int LIMIT  = DEPTH - PAD;

  localparam int PH_IDLE  = 0;
  localparam int PH_LOAD  = 1;
  localparam int PH_PAD   = 2;
  localparam int PH_START = 3;
  localparam int PH_WAIT  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [7:0]        s_data = 8'h00;
  logic              s_last = 1'b0;
  logic [ADDR_W-1:0] mem_addr_b;
  logic              mem_we_b;
  logic [7:0]        mem_data_in_b;
  logic              filt_start;
  logic              filt_done = 1'b0;
  logic              busy;
  logic [ADDR_W:0]   sample_count;
  logic              overflow;

  // Second instance with a longer start pulse and small memory.
  logic       b_valid = 1'b0;
  logic       b_ready;
  logic [7:0] b_data = 8'h00;
  logic       b_last = 1'b0;
  logic [3:0] b_addr;
  logic       b_we;
  logic [7:0] b_wdata;
  logic       b_start;
  logic       b_done = 1'b0;
  logic       b_busy;
  logic [4:0] b_count;
  logic       b_ovf;

  fir_sample_loader #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .PAD(PAD), .START_LEN(1)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .mem_addr_b(mem_addr_b), .mem_we_b(mem_we_b),
    .mem_data_in_b(mem_data_in_b), .filt_start(filt_start), .filt_done(filt_done),
    .busy(busy), .sample_count(sample_count), .overflow(overflow)
  );

  fir_sample_loader #(
    .ADDR_W(4), .DEPTH(16), .PAD(4), .START_LEN(3)
  ) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .s_last(b_last), .mem_addr_b(b_addr), .mem_we_b(b_we),
    .mem_data_in_b(b_wdata), .filt_start(b_start), .filt_done(b_done),
    .busy(b_busy), .sample_count(b_count), .overflow(b_ovf)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int wr_total = 0;
  int start_total = 0;
  int last_addr = 0;

  // Frame-level model: phase, samples written, pad/start cycles remaining.
  bit       m_valid = 1'b0;
  int       m_phase = PH_IDLE;
  int       m_count = 0;
  bit       m_ovf = 1'b0;
  int       m_ptr = 0;
  int       m_left = 0;
  bit       m_we = 1'b0;
  int       m_addr = 0;
  int       m_data = 0;

  always @(posedge clk) begin
    m_valid <= 1'b1;
    m_we    <= 1'b0;
    if (rst) begin
      m_phase <= PH_IDLE;
      m_count <= 0;
      m_ovf   <= 1'b0;
      m_ptr   <= 0;
    end else begin
      case (m_phase)
        PH_IDLE: begin
          if (s_valid) begin
            m_we    <= 1'b1;
            m_addr  <= 0;
            m_data  <= int'(s_data);
            m_ptr   <= 1;
            m_count <= 1;
            m_ovf   <= 1'b0;
            m_phase <= s_last ? PH_PAD : PH_LOAD;
            m_left  <= PAD;
          end
        end
        PH_LOAD: begin
          if (s_valid) begin
            if (m_count < LIMIT) begin
              m_we    <= 1'b1;
              m_addr  <= m_ptr;
              m_data  <= int'(s_data);
              m_ptr   <= m_ptr + 1;
              m_count <= m_count + 1;
            end else begin
              m_ovf <= 1'b1;
            end
            m_phase <= s_last ? PH_PAD : PH_LOAD;
            m_left  <= PAD;
          end
        end
        PH_PAD: begin
          m_we   <= 1'b1;
          m_addr <= m_ptr;
          m_data <= 0;
          m_ptr  <= m_ptr + 1;
          if (m_left == 1) begin
            m_phase <= PH_START;
            m_left  <= 1;
          end else begin
            m_left <= m_left - 1;
          end
        end
        PH_START: begin
          if (m_left == 1) m_phase <= PH_WAIT;
          else m_left <= m_left - 1;
        end
        PH_WAIT: begin
          if (filt_done) m_phase <= PH_IDLE;
        end
        default: m_phase <= PH_IDLE;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the main DUT against the model.
  task automatic compare_cycle();
    if (m_valid) begin
      check("s_ready", 32'(s_ready), 32'(m_phase <= PH_LOAD));
      check("busy", 32'(busy), 32'(m_phase != PH_IDLE));
      check("filt_start", 32'(filt_start), 32'(m_phase == PH_START));
      check("mem_we_b", 32'(mem_we_b), 32'(m_we));
      if (m_we) begin
        check("mem_addr_b", 32'(mem_addr_b), 32'(m_addr));
        check("mem_data_in_b", 32'(mem_data_in_b), 32'(m_data));
      end
      check("sample_count", 32'(sample_count), 32'(m_count));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
    if (mem_we_b) begin
      wr_total++;
      last_addr = int'(mem_addr_b);
    end
    if (filt_start) start_total++;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  // Wait for the start pulse, idle 'delay' cycles in WAIT, then pulse done.
  task automatic complete_frame(input int delay);
    int n = 0;
    while (!filt_start && n < 40) begin
      tick();
      n++;
    end
    check("start_seen", 32'(filt_start), 32'd1);
    for (int i = 0; i < delay; i++) tick();
    check("busy_before_done", 32'(busy), 32'd1);
    filt_done = 1'b1;
    tick();
    filt_done = 1'b0;
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int w0;
    int s0;
    int n;
    int sc;
    int rv;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_mem_we_b", 32'(mem_we_b), 32'd0);
    check("rst_filt_start", 32'(filt_start), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(sample_count), 32'd0);
    tick();

    // 15-beat frame: 64 x5, 0 x5, 32 x5 with s_valid held high.
    w0 = wr_total;
    s0 = start_total;
    for (int i = 0; i < 15; i++) begin
      s_valid = 1'b1;
      s_data  = (i < 5) ? 8'd64 : ((i < 10) ? 8'd0 : 8'd32);
      s_last  = (i == 14);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    complete_frame(4);
    check("f1_writes", 32'(wr_total - w0), 32'd19);
    check("f1_last_addr", 32'(last_addr), 32'd18);
    check("f1_start_cycles", 32'(start_total - s0), 32'd1);
    check("f1_count", 32'(sample_count), 32'd15);
    check("f1_model_count", 32'(m_count), 32'd15);
    check("f1_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("f1_count_hold", 32'(sample_count), 32'd15);

    // Single-beat frame 0x7F, done 20 cycles into WAIT.
    w0 = wr_total;
    s_valid = 1'b1;
    s_data  = 8'h7F;
    s_last  = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("f2_first_addr", 32'(mem_addr_b), 32'd0);
    check("f2_first_data", 32'(mem_data_in_b), 32'h7F);
    complete_frame(20);
    check("f2_writes", 32'(wr_total - w0), 32'd5);
    check("f2_last_addr", 32'(last_addr), 32'd4);
    check("f2_count", 32'(sample_count), 32'd1);

    // Bursty 6-sample frame; done pulsed during PAD must be ignored.
    w0 = wr_total;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'hF0 + i);
      s_last  = (i == 5);
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'h55;
      if (i != 5) tick();
    end
    filt_done = 1'b1;
    tick();
    tick();
    filt_done = 1'b0;
    check("f3_busy_in_pad", 32'(busy), 32'd1);
    complete_frame(3);
    check("f3_writes", 32'(wr_total - w0), 32'd10);
    check("f3_last_addr", 32'(last_addr), 32'd9);
    check("f3_count", 32'(sample_count), 32'd6);

    // Reset during the third pad write aborts the frame.
    w0 = wr_total;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h21 + i);
      s_last  = (i == 2);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    tick();
    tick();
    check("f4_third_pad_addr", 32'(mem_addr_b), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("f4_we_after_rst", 32'(mem_we_b), 32'd0);
    check("f4_start_after_rst", 32'(filt_start), 32'd0);
    check("f4_busy_after_rst", 32'(busy), 32'd0);
    check("f4_writes", 32'(wr_total - w0), 32'd6);
    tick();
    check("f4_no_late_write", 32'(mem_we_b), 32'd0);
    s_valid = 1'b1;
    s_data  = 8'h11;
    s_last  = 1'b1;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("f5_restart_we", 32'(mem_we_b), 32'd1);
    check("f5_restart_addr", 32'(mem_addr_b), 32'd0);
    complete_frame(2);

    // 1030-beat frame overruns the 1020-sample limit.
    w0 = wr_total;
    for (int i = 1; i <= 1030; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      s_last  = (i == 1030);
      tick();
      if (i == 1020) check("f6_ovf_at_1020", 32'(overflow), 32'd0);
      if (i == 1021) check("f6_ovf_at_1021", 32'(overflow), 32'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    complete_frame(3);
    check("f6_writes", 32'(wr_total - w0), 32'd1024);
    check("f6_last_addr", 32'(last_addr), 32'd1023);
    check("f6_count", 32'(sample_count), 32'd1020);
    check("f6_overflow", 32'(overflow), 32'd1);

    // START_LEN=3 instance: 3-cycle start, s_ready low while busy.
    b_valid = 1'b1;
    b_data  = 8'h20;
    b_last  = 1'b1;
    tick();
    b_valid = 1'b0;
    b_last  = 1'b0;
    n  = 0;
    sc = 0;
    rv = 0;
    while (b_busy && n < 40) begin
      tick();
      n++;
      if (b_start) sc++;
      if (b_busy && b_ready) rv++;
      b_done = (sc == 3 && !b_start) ? 1'b1 : 1'b0;
    end
    b_done = 1'b0;
    check("b_start_cycles", 32'(sc), 32'd3);
    check("b_ready_while_busy", 32'(rv), 32'd0);
    check("b_idle", 32'(b_busy), 32'd0);
    check("b_count", 32'(b_count), 32'd1);
    check("b_ready_idle", 32'(b_ready), 32'd1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
